// File: rtl/run_sequencer_if.sv
// Host/downstream handshake bundle for run_sequencer: start command, done
// return, run pulse and sequence status.
interface run_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] num_runs;
   logic             done_in;
   logic             out_run;
   logic             busy;
   logic             seq_done;
   logic [CNT_W-1:0] run_cnt;
   logic             timeout_err;

   modport master (
      output start, num_runs, done_in,
      input  out_run, busy, seq_done, run_cnt, timeout_err
   );

   modport slave (
      input  start, num_runs, done_in,
      output out_run, busy, seq_done, run_cnt, timeout_err
   );
endinterface

// File: rtl/run_sequencer.sv
// Issues a programmed number of run pulses to fsm_basic, waiting for each done
// plus a fixed idle gap, with a watchdog on every wait.
module run_sequencer #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64,
   parameter int GAP     = 2
) (
   input  logic              clk,
   input  logic              rst,
   run_sequencer_if.slave    bus
);
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [TMR_W-1:0] timer;
   logic [GAP_W-1:0] gap_cnt;
   logic             out_run;
   logic             busy;
   logic             seq_done;
   logic             timeout_err;

   assign cnt_inc = run_cnt + CNT_W'(1);

   // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (bus.start) state_nxt = (bus.num_runs != '0) ? S_ISSUE : S_FINISH;
         S_ISSUE:
            state_nxt = S_WAIT;
         S_WAIT:
            // done wins over timeout in the last window cycle
            if (bus.done_in)                         state_nxt = (cnt_inc == target) ? S_FINISH : S_GAP;
            else if (timer == TMR_W'(TIMEOUT - 1))   state_nxt = S_ERROR;
         S_GAP:
            if (gap_cnt == GAP_W'(GAP - 1)) state_nxt = S_ISSUE;
         S_FINISH,
         S_ERROR:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         target      <= '0;
         run_cnt     <= '0;
         timer       <= '0;
         gap_cnt     <= '0;
         out_run     <= 1'b0;
         busy        <= 1'b0;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         // outputs are registered copies of the state being entered
         out_run  <= (state_nxt == S_ISSUE);
         busy     <= (state_nxt != S_IDLE);
         seq_done <= (state_nxt == S_FINISH) || (state_nxt == S_ERROR);

         case (state)
            S_IDLE:
               if (bus.start) begin
                  target      <= bus.num_runs;
                  run_cnt     <= '0;
                  timeout_err <= 1'b0;
               end
            S_ISSUE:
               timer <= '0;
            S_WAIT: begin
               timer   <= timer + TMR_W'(1);
               gap_cnt <= '0;
               if (bus.done_in) run_cnt <= cnt_inc;
            end
            S_GAP:
               gap_cnt <= gap_cnt + GAP_W'(1);
            default: ;
         endcase

         if (state_nxt == S_ERROR) timeout_err <= 1'b1;
      end
   end

   assign bus.out_run     = out_run;
   assign bus.busy        = busy;
   assign bus.seq_done    = seq_done;
   assign bus.run_cnt     = run_cnt;
   assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer against a cycle-schedule model of the
// run/wait/gap/timeout rules, plus directed scenarios with literal timings.
module tb_run_sequencer;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 64;
   localparam int GAP     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   run_sequencer_if #(.CNT_W(CNT_W)) bus ();

   run_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: schedule of edge numbers ----------------
   int cyc      = 0;
   bit m_valid  = 0;
   bit m_active = 0;
   int m_cnt    = 0;
   bit m_err    = 0;
   int m_target = 0;
   int pulse_e  = -100;
   int end_e    = -100;
   bit e_run, e_busy, e_sdone;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_valid  = 1;
         m_active = 0;
         m_cnt    = 0;
         m_err    = 0;
         m_target = 0;
         pulse_e  = -100;
         end_e    = -100;
      end else if (!m_active) begin
         if (bus.start) begin
            m_active = 1;
            m_cnt    = 0;
            m_err    = 0;
            m_target = int'(bus.num_runs);
            end_e    = -100;
            if (bus.num_runs == 0) end_e = cyc;
            else                   pulse_e = cyc;
         end
      end else if (end_e >= 0) begin
         if (cyc == end_e + 1) m_active = 0;
      end else if (cyc >= pulse_e + 2) begin
         // done window: edges pulse+2 .. pulse+1+TIMEOUT
         if (bus.done_in) begin
            m_cnt++;
            if (m_cnt == m_target) end_e = cyc;
            else                   pulse_e = cyc + GAP;
         end else if (cyc == pulse_e + 1 + TIMEOUT) begin
            m_err = 1;
            end_e = cyc;
         end
      end
      e_run   = m_active && (cyc == pulse_e);
      e_busy  = m_active;
      e_sdone = m_active && (cyc == end_e);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("out_run",     bus.out_run,     e_run);
         check("busy",        bus.busy,        e_busy);
         check("seq_done",    bus.seq_done,    e_sdone);
         check("run_cnt",     bus.run_cnt,     m_cnt);
         check("timeout_err", bus.timeout_err, m_err);
      end
   end

   // ---------------- fsm_basic stand-in: done after a programmable delay ----------------
   int resp_delay = 4;   // 0 = never answers
   int done_len   = 1;
   bit spur_en    = 0;
   int done_cd    = 0;
   int done_hold  = 0;

   always @(negedge clk) begin
      logic d;
      #1;
      d = 1'b0;
      if (done_hold > 0) begin
         d = 1'b1;
         done_hold--;
      end
      if (done_cd > 0) begin
         done_cd--;
         if (done_cd == 0) begin
            d = 1'b1;
            done_hold = done_len - 1;
         end
      end
      if (bus.out_run && resp_delay > 0) done_cd = resp_delay;
      if (spur_en && $urandom_range(0, 7) == 0) d = 1'b1;
      bus.done_in = d;
   end

   // ---------------- monitor ----------------
   int pulse_q[$];
   int sdone_n   = 0;
   int sdone_cyc = -1;
   int start_cyc = -1;

   always @(negedge clk) begin
      if (m_valid) begin
         if (bus.out_run === 1'b1) pulse_q.push_back(cyc);
         if (bus.seq_done === 1'b1) begin
            sdone_n++;
            sdone_cyc = cyc;
         end
      end
   end

   task automatic mon_clear();
      pulse_q.delete();
      sdone_n   = 0;
      sdone_cyc = -1;
   endtask

   function automatic int pulse_at(input int i);
      return (i < pulse_q.size()) ? pulse_q[i] : -1000;
   endfunction

   task automatic run_seq(input int n, input int len);
      @(negedge clk);
      #2;
      bus.start    = 1'b1;
      bus.num_runs = CNT_W'(n);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 0) start_cyc = cyc;
      end
      #2;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((m_active || bus.busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait_busy", bus.busy, 0);
   endtask

   task automatic pulse_reset(input int cycles);
      @(negedge clk);
      #2;
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.start    = 1'b0;
      bus.num_runs = '0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_run_cnt", bus.run_cnt, 0);
      check("rst_err", bus.timeout_err, 0);

      // single run, done 4 cycles after the pulse
      mon_clear();
      resp_delay = 4;
      run_seq(1, 1);
      check("single_latency_run", bus.out_run, 1);
      wait_idle(200);
      check("single_pulses", pulse_q.size(), 1);
      check("single_sdone_n", sdone_n, 1);
      check("single_sdone_dly", sdone_cyc - pulse_at(0), 5);
      check("single_cnt", bus.run_cnt, 1);

      // three runs: pulse spacing = 4 + 1 + GAP
      mon_clear();
      run_seq(3, 1);
      wait_idle(300);
      check("three_pulses", pulse_q.size(), 3);
      check("three_space1", pulse_at(1) - pulse_at(0), 7);
      check("three_space2", pulse_at(2) - pulse_at(1), 7);
      check("three_sdone_dly", sdone_cyc - pulse_at(2), 5);
      check("three_cnt", bus.run_cnt, 3);
      check("three_sdone_n", sdone_n, 1);

      // timeout with no done at all
      mon_clear();
      resp_delay = 0;
      run_seq(2, 1);
      wait_idle(300);
      check("to_pulses", pulse_q.size(), 1);
      check("to_sdone_dly", sdone_cyc - pulse_at(0), TIMEOUT + 1);
      check("to_err", bus.timeout_err, 1);
      check("to_cnt", bus.run_cnt, 0);
      repeat (5) @(negedge clk);
      check("to_err_sticky", bus.timeout_err, 1);
      resp_delay = 4;
      run_seq(1, 1);
      check("to_err_cleared", bus.timeout_err, 0);
      wait_idle(200);

      // done in the last wait cycle is accepted; one later times out
      mon_clear();
      resp_delay = TIMEOUT;
      run_seq(1, 1);
      wait_idle(300);
      check("edge_in_err", bus.timeout_err, 0);
      check("edge_in_cnt", bus.run_cnt, 1);
      check("edge_in_dly", sdone_cyc - pulse_at(0), TIMEOUT + 1);
      resp_delay = TIMEOUT + 1;
      run_seq(1, 1);
      wait_idle(300);
      check("edge_out_err", bus.timeout_err, 1);
      check("edge_out_cnt", bus.run_cnt, 0);

      // zero runs requested
      mon_clear();
      resp_delay = 4;
      run_seq(0, 1);
      wait_idle(50);
      check("zero_pulses", pulse_q.size(), 0);
      check("zero_sdone_n", sdone_n, 1);
      check("zero_sdone_at", sdone_cyc - start_cyc, 0);

      // start held 5 cycles: one sequence, then a fresh one after the IDLE cycle
      mon_clear();
      resp_delay = 1;
      run_seq(1, 5);
      wait_idle(100);
      check("hold_pulses", pulse_q.size(), 2);
      check("hold_sdone_n", sdone_n, 2);

      // interference: re-start while busy, done held through the gap
      mon_clear();
      resp_delay = 4;
      done_len   = 4;
      run_seq(3, 1);
      repeat (2) @(negedge clk);
      #2;
      bus.start    = 1'b1;
      bus.num_runs = CNT_W'(7);
      repeat (2) @(negedge clk);
      #2;
      bus.start = 1'b0;
      wait_idle(300);
      done_len = 1;
      check("intf_pulses", pulse_q.size(), 3);
      check("intf_space", pulse_at(1) - pulse_at(0), 7);
      check("intf_cnt", bus.run_cnt, 3);
      check("intf_sdone_n", sdone_n, 1);

      // reset mid-wait aborts silently; the late done is dropped
      mon_clear();
      resp_delay = 30;
      run_seq(3, 1);
      repeat (8) @(negedge clk);
      pulse_reset(2);
      @(negedge clk);
      check("rstw_busy", bus.busy, 0);
      check("rstw_run", bus.out_run, 0);
      check("rstw_cnt", bus.run_cnt, 0);
      repeat (40) @(negedge clk);
      check("rstw_cnt_late", bus.run_cnt, 0);
      check("rstw_sdone_n", sdone_n, 0);

      // full-range target must not wrap
      mon_clear();
      resp_delay = 1;
      run_seq((1 << CNT_W) - 1, 1);
      wait_idle(4000);
      check("max_pulses", pulse_q.size(), (1 << CNT_W) - 1);
      check("max_cnt", bus.run_cnt, (1 << CNT_W) - 1);
      check("max_err", bus.timeout_err, 0);

      // randomized sequences against the model
      for (int it = 0; it < 25; it++) begin
         int dsel;
         dsel       = $urandom_range(0, 9);
         resp_delay = (dsel == 0) ? 0 : (dsel == 1) ? TIMEOUT : $urandom_range(1, 8);
         done_len   = $urandom_range(1, 2);
         spur_en    = ($urandom_range(0, 2) == 0);
         run_seq($urandom_range(0, 5), $urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            pulse_reset($urandom_range(1, 2));
         end
         spur_en = 0;
         wait_idle(1000);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
